dmem_sum_master: RTL and testbench

- Bus initiator for the data memory port: drives we/addr/wdata and samples rdata. It performs in hardware the array-sum job the MIPS test program does in software.
- On start it reads element count n from N_ADDR, then sums words ARR_BASE..ARR_BASE+n-1, writes the total to SUM_ADDR, and pulses done.
- Shares the memory port with the CPU through an external mux; it owns the port while busy=1.

---
 rtl/dmem_sum_master.sv | 110 +++++++++++
 tb/tb_dmem_sum_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sum_master.sv
// rtl/dmem_sum_master.sv - bus initiator that sums a word array in data memory
// Reads n, accumulates n words from ARR_BASE, writes the sum to SUM_ADDR, pulses done.
module dmem_sum_master #(
  parameter logic [31:0] N_ADDR   = 32'd0,
  parameter logic [31:0] SUM_ADDR = 32'd1,
  parameter logic [31:0] ARR_BASE = 32'd2,
  parameter logic [31:0] MAX_N    = 32'd62
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] sum_out
);

  typedef enum logic [2:0] {IDLE, RD_N, RD_EL, WR_SUM, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sum_q, sum_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= 32'd0;
      idx_q   <= 32'd0;
      acc_q   <= 32'd0;
      sum_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  // Memory outputs are decoded from state so an async reset drops mem_we at once.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = RD_N;
          acc_d   = 32'd0;
          idx_d   = 32'd0;
          err_d   = 1'b0;
        end
      end
      RD_N: begin
        mem_addr = N_ADDR;
        n_d      = mem_rdata;
        if (mem_rdata == 32'd0) begin
          state_d = WR_SUM;
        end else if (mem_rdata > MAX_N) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RD_EL;
        end
      end
      RD_EL: begin
        mem_addr = ARR_BASE + idx_q;
        acc_d    = acc_q + mem_rdata;
        idx_d    = idx_q + 32'd1;
        if (idx_q == n_q - 32'd1) begin
          state_d = WR_SUM;
        end
      end
      WR_SUM: begin
        mem_we    = 1'b1;
        mem_addr  = SUM_ADDR;
        mem_wdata = acc_q;
        sum_d     = acc_q;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err     = err_q;
  assign sum_out = sum_q;

endmodule

// File: tb/tb_dmem_sum_master.sv
// tb/tb_dmem_sum_master.sv - scoreboard bench for dmem_sum_master
// Memory model commits writes at negedge; expected per-cycle bus activity is queued per run.
module tb_dmem_sum_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] sum_out;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  logic [31:0] mem [0:63];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dmem_sum_master dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err), .sum_out(sum_out)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'd0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr[5:0]] = mem_wdata;
      wr_count = wr_count + 1;
    end
  end

  // Scoreboard consumer: one expected entry per cycle, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks += 6;
      if (mem_addr !== mon_e.addr) begin errors++; $display("FAIL addr t=%0t got %h expected %h", $time, mem_addr, mon_e.addr); end
      if (mem_we !== mon_e.we) begin errors++; $display("FAIL we t=%0t got %b expected %b", $time, mem_we, mon_e.we); end
      if (mem_wdata !== mon_e.wdata) begin errors++; $display("FAIL wdata t=%0t got %h expected %h", $time, mem_wdata, mon_e.wdata); end
      if (busy !== mon_e.busy) begin errors++; $display("FAIL busy t=%0t got %b expected %b", $time, busy, mon_e.busy); end
      if (done !== mon_e.done) begin errors++; $display("FAIL done t=%0t got %b expected %b", $time, done, mon_e.done); end
      if (err !== mon_e.err) begin errors++; $display("FAIL err t=%0t got %b expected %b", $time, err, mon_e.err); end
    end
  end

  function automatic exp_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic b, input logic dn, input logic er);
    exp_t e;
    e.addr = a; e.we = w; e.wdata = d; e.busy = b; e.done = dn; e.err = er;
    return e;
  endfunction

  task automatic push_run();
    logic [31:0] n;
    logic [31:0] s;
    n = mem[0];
    s = 32'd0;
    sb.push_back(mk(32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0));
    if (n > 32'd62) begin
      sb.push_back(mk(32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1));
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        s = s + mem[2 + i];
        sb.push_back(mk(32'(2 + i), 1'b0, 32'd0, 1'b1, 1'b0, 1'b0));
      end
      sb.push_back(mk(32'd1, 1'b1, s, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk(32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0));
    end
  endtask

  task automatic push_idle();
    sb.push_back(mk(32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic set_default_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'd5;
    for (int i = 2; i <= 6; i++) mem[i] = 32'(i - 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    push_run();
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    set_default_mem();
    #1;
    checks += 4;
    if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem got we=%b addr=%h wdata=%h expected 0", mem_we, mem_addr, mem_wdata); end
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b expected 0", busy, done); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err); end
    if (sum_out !== 32'd0) begin errors++; $display("FAIL reset_sum got %h expected 0", sum_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int w0;
    set_default_mem();
    w0 = wr_count;
    pulse_start();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks += 5;
    if (sb.size() != 0) begin errors++; $display("FAIL basic_timeout got %0d pending expected 0", sb.size()); end
    if (mem[1] !== 32'd15) begin errors++; $display("FAIL basic_mem1 got %h expected %h", mem[1], 32'd15); end
    if (sum_out !== 32'd15) begin errors++; $display("FAIL basic_sum got %h expected %h", sum_out, 32'd15); end
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b expected 0", err); end
    if (wr_count - w0 != 1) begin errors++; $display("FAIL basic_writes got %0d expected 1", wr_count - w0); end
  endtask

  task automatic test_err();
    int w0;
    mem[0] = 32'd63;
    mem[1] = 32'h0BAD_F00D;
    w0 = wr_count;
    pulse_start();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks += 4;
    if (sb.size() != 0) begin errors++; $display("FAIL err_timeout got %0d pending expected 0", sb.size()); end
    if (mem[1] !== 32'h0BAD_F00D) begin errors++; $display("FAIL err_mem1 got %h expected %h", mem[1], 32'h0BAD_F00D); end
    if (sum_out !== 32'd15) begin errors++; $display("FAIL err_sum got %h expected %h", sum_out, 32'd15); end
    if (wr_count != w0) begin errors++; $display("FAIL err_writes got %0d expected 0", wr_count - w0); end
    repeat (3) @(negedge clk);
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL err_hold got %b expected 1", err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL err_idle got busy=%b expected 0", busy); end
  endtask

  task automatic test_zero();
    int w0;
    mem[0] = 32'd0;
    mem[1] = 32'hA5A5_A5A5;
    w0 = wr_count;
    pulse_start();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks += 4;
    if (sb.size() != 0) begin errors++; $display("FAIL zero_timeout got %0d pending expected 0", sb.size()); end
    if (mem[1] !== 32'd0) begin errors++; $display("FAIL zero_mem1 got %h expected 0", mem[1]); end
    if (sum_out !== 32'd0) begin errors++; $display("FAIL zero_sum got %h expected 0", sum_out); end
    if (wr_count - w0 != 1) begin errors++; $display("FAIL zero_writes got %0d expected 1", wr_count - w0); end
  endtask

  task automatic test_wrap();
    mem[0] = 32'd2;
    mem[2] = 32'hFFFF_FFFF;
    mem[3] = 32'd2;
    pulse_start();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks += 3;
    if (sb.size() != 0) begin errors++; $display("FAIL wrap_timeout got %0d pending expected 0", sb.size()); end
    if (mem[1] !== 32'd1) begin errors++; $display("FAIL wrap_mem1 got %h expected 1", mem[1]); end
    if (sum_out !== 32'd1) begin errors++; $display("FAIL wrap_sum got %h expected 1", sum_out); end
  endtask

  task automatic test_reset_mid();
    int w0;
    set_default_mem();
    mem[1] = 32'hDEAD_BEEF;
    w0 = wr_count;
    @(negedge clk);
    push_run();
    while (sb.size() > 4) void'(sb.pop_back());
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks += 4;
    if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL midrst_mem got we=%b addr=%h wdata=%h expected 0", mem_we, mem_addr, mem_wdata); end
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_flags got busy=%b done=%b err=%b expected 0", busy, done, err); end
    if (sum_out !== 32'd0) begin errors++; $display("FAIL midrst_sum got %h expected 0", sum_out); end
    if (sb.size() != 0) begin errors++; $display("FAIL midrst_pending got %0d expected 0", sb.size()); end
    repeat (2) @(negedge clk);
    checks += 2;
    if (mem[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midrst_mem1 got %h expected %h", mem[1], 32'hDEAD_BEEF); end
    if (wr_count != w0) begin errors++; $display("FAIL midrst_writes got %0d expected 0", wr_count - w0); end
    rst_n = 1'b1;
    pulse_start();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks += 3;
    if (sb.size() != 0) begin errors++; $display("FAIL rerun_timeout got %0d pending expected 0", sb.size()); end
    if (mem[1] !== 32'd15) begin errors++; $display("FAIL rerun_mem1 got %h expected %h", mem[1], 32'd15); end
    if (sum_out !== 32'd15) begin errors++; $display("FAIL rerun_sum got %h expected %h", sum_out, 32'd15); end
  endtask

  task automatic test_start_held();
    int w0;
    set_default_mem();
    w0 = wr_count;
    @(negedge clk);
    push_run();
    push_idle();
    push_run();
    start = 1'b1;
    repeat (10) @(posedge clk);
    #2 start = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks += 2;
    if (sb.size() != 0) begin errors++; $display("FAIL held_timeout got %0d pending expected 0", sb.size()); end
    if (wr_count - w0 != 2) begin errors++; $display("FAIL held_writes got %0d expected 2", wr_count - w0); end
  endtask

  task automatic test_back_to_back_ignored();
    int w0;
    set_default_mem();
    mem[2] = 32'd100;
    w0 = wr_count;
    pulse_start();
    push_idle();
    push_idle();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 8);
    end
    @(posedge clk);
    #2 start = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks += 3;
    if (sb.size() != 0) begin errors++; $display("FAIL ignore_timeout got %0d pending expected 0", sb.size()); end
    if (wr_count - w0 != 1) begin errors++; $display("FAIL ignore_writes got %0d expected 1", wr_count - w0); end
    if (sum_out !== 32'd114) begin errors++; $display("FAIL ignore_sum got %h expected %h", sum_out, 32'd114); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_zero();
    test_wrap();
    test_reset_mid();
    test_start_held();
    test_back_to_back_ignored();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
